ram_handshake_responder: RTL and testbench
==========================================

Name: ram_handshake_responder

Overview:
- Clocked memory responder for the MFA/MFC four-phase handshake used by the SPARC load/store path.
- Accepts byte, halfword and word stores and signed or unsigned loads. Memory is a big-endian byte array.
- Inserts a programmable number of wait states before asserting MFC.
- Slots in place of the combinational RAM model wherever a cycle-accurate memory with latency is required.

Parameters:
- ADDR_W, 8, address width; memory holds 2**ADDR_W bytes.
- WAIT_CYCLES, 2, wait states between request capture and the access; legal range 0..15.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- MFA  input  1  memory function active; the request strobe from the initiator.
- opcode  input  6  access type; encodings listed under Behaviour.
- addr  input  ADDR_W  byte address.
- data_in  input  32  store data; the operand is right-justified.
- data_out  output  32  load result; registered.
- MFC  output  1  memory function complete; registered.
- err  output  1  illegal opcode flag; valid while MFC is high.

Behaviour:
- Opcodes:
  - 0x04 store word (SW), 0x05 store byte (SB), 0x06 store halfword (SH).
  - 0x01 load unsigned byte (LDUB), 0x02 load unsigned halfword (LDUH), 0x08 load word (LD).
  - 0x09 load signed byte (LDSB), 0x0A load signed halfword (LDSH).
  - Any other value is illegal.
- Byte order is big-endian. The byte at addr goes to the most significant lane of the operand.
  - Halfword: bytes addr, addr+1.
  - Word: bytes addr..addr+3.
- Address increments wrap modulo 2**ADDR_W.
- No alignment check: misaligned addresses are legal and are accessed bytewise.
- Store operands:
  - SB writes data_in[7:0].
  - SH writes data_in[15:0].
  - SW writes data_in[31:0].
- Load results:
  - Unsigned loads zero-extend to 32 bits.
  - Signed loads sign-extend from bit 7 (byte) or bit 15 (halfword).
- Reset:
  - MFC=0, err=0, data_out=0, state=IDLE, wait counter=0.
  - Memory contents are not reset.
- FSM states: IDLE, WAIT, ACCESS, DONE.
  - IDLE: on a clock edge with MFA=1, latch opcode, addr and data_in. Go to WAIT, or to ACCESS if WAIT_CYCLES=0.
  - WAIT: count WAIT_CYCLES clocks, then go to ACCESS.
  - ACCESS, one cycle:
    - Store: write the byte lanes.
    - Legal load: register the result into data_out.
    - Illegal opcode: set err=1, no write, data_out unchanged.
    - Set MFC=1 and go to DONE.
  - DONE: hold MFC=1 and data_out. On the first edge with MFA sampled 0, clear MFC and err and go to IDLE.
- Latency: MFA rising edge to MFC=1 is WAIT_CYCLES+2 clock edges.
- Inputs are captured once at request. Changes to opcode, addr or data_in during WAIT, ACCESS or DONE are ignored.
- Request handling:
  - MFA dropping before MFC asserts does not abort the request. The transaction completes and MFC pulses for exactly one cycle, because MFA is already low in DONE.
  - A new request is accepted only from IDLE. MFA held high across DONE→IDLE starts a new transaction on the next edge.
- data_out holds the last load result through stores and idle periods.
- Reset asserted mid-transaction:
  - Aborts immediately and no write occurs if ACCESS has not been reached.
  - A write already performed in ACCESS is retained.

Decomposition:
- Package ram_pkg holds:
  - opcode localparams: OP_LDUB, OP_LDUH, OP_SW, OP_SB, OP_SH, OP_LD, OP_LDSB, OP_LDSH;
  - the FSM state enum;
  - the function is_store(opcode).
- One combinational sub-module, ram_lane_align:
  - inputs: opcode and the 4 bytes fetched at addr..addr+3;
  - outputs: the extended load word and the per-byte write enables with lane data for stores.
- FSM, wait counter and byte array stay in the top module.

Test Plan:
- SB 0x01@0x00, SB 0x23@0x01, SH 0x4567@0x02, then LD@0x00 → data_out=0x01234567, MFC high 4 cycles after MFA (WAIT_CYCLES=2).
- SW 0x89ABCDEF@0x04, then:
  - LDUB@0x04 → 0x00000089;
  - LDSB@0x06 → 0xFFFFFFCD;
  - LDSB@0x00 → 0x00000001.
- After the above:
  - LDUH@0x06 → 0x0000CDEF;
  - LDSH@0x06 → 0xFFFFCDEF;
  - LDUH@0x03 (misaligned) → 0x00006789;
  - LD@0xFE after SW 0xAABBCCDD@0xFE → 0xAABBCCDD (wrap check).
- Opcode 0x3F with MFA high → MFC=1 and err=1, memory and data_out unchanged. Both flags clear one edge after MFA drops.
- Change addr and data_in during WAIT of SW 0x11223344@0x10, then LD@0x10 → 0x11223344.
- Assert reset during WAIT of SW 0xDEADBEEF@0x20 → MFC=0, data_out=0, state IDLE. A subsequent LD@0x20 returns the prior contents.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared opcode encodings, FSM state type and opcode helpers
// for the MFA/MFC handshake memory responder.
package ram_pkg;

  localparam logic [5:0] OP_LDUB = 6'h01;
  localparam logic [5:0] OP_LDUH = 6'h02;
  localparam logic [5:0] OP_SW   = 6'h04;
  localparam logic [5:0] OP_SB   = 6'h05;
  localparam logic [5:0] OP_SH   = 6'h06;
  localparam logic [5:0] OP_LD   = 6'h08;
  localparam logic [5:0] OP_LDSB = 6'h09;
  localparam logic [5:0] OP_LDSH = 6'h0A;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ACCESS,
    DONE
  } state_t;

  function automatic logic is_store(
    input logic [5:0] op
  );
    return (op == OP_SW) ||
           (op == OP_SB) ||
           (op == OP_SH);
  endfunction

  function automatic logic is_load(
    input logic [5:0] op
  );
    return (op == OP_LDUB) ||
           (op == OP_LDUH) ||
           (op == OP_LD)   ||
           (op == OP_LDSB) ||
           (op == OP_LDSH);
  endfunction

endpackage

// File: rtl/ram_handshake_responder_if.sv
// Request/response bundle between an initiator and the
// handshake memory responder.
interface ram_handshake_responder_if #(
  parameter int ADDR_W = 8
);
  logic              MFA;
  logic [5:0]        opcode;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              MFC;
  logic              err;

  modport master (
    output MFA, opcode, addr, data_in,
    input  data_out, MFC, err
  );

  modport slave (
    input  MFA, opcode, addr, data_in,
    output data_out, MFC, err
  );
endinterface

// File: rtl/ram_lane_align.sv
// Big-endian lane steering: load extension and store byte enables.
// Lane i (bits [8*(3-i)+:8]) is the byte at addr+i.
module ram_lane_align
  import ram_pkg::*;
(
  input  logic [5:0]  opcode,
  input  logic [31:0] rd_bytes,
  input  logic [31:0] data_in,
  output logic [31:0] load_word,
  output logic [3:0]  we,
  output logic [31:0] wr_bytes
);

  always_comb begin
    load_word = '0;
    we        = '0;
    wr_bytes  = '0;
    unique case (opcode)
      OP_LDUB: load_word = {24'h0, rd_bytes[31:24]};
      OP_LDSB: load_word = {{24{rd_bytes[31]}},
                            rd_bytes[31:24]};
      OP_LDUH: load_word = {16'h0, rd_bytes[31:16]};
      OP_LDSH: load_word = {{16{rd_bytes[31]}},
                            rd_bytes[31:16]};
      OP_LD:   load_word = rd_bytes;
      OP_SB: begin
        we             = 4'b0001;
        wr_bytes[31:24] = data_in[7:0];
      end
      OP_SH: begin
        we              = 4'b0011;
        wr_bytes[31:16] = data_in[15:0];
      end
      OP_SW: begin
        we       = 4'b1111;
        wr_bytes = data_in;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/ram_handshake_responder.sv
// Byte-addressed big-endian memory answering MFA requests with
// MFC after a programmable number of wait states.
module ram_handshake_responder
  import ram_pkg::*;
#(
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input logic clk,
  input logic reset,
  ram_handshake_responder_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [5:0]        op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       din_q, din_d;
  logic [31:0]       dout_q, dout_d;
  logic              mfc_q, mfc_d;
  logic              err_q, err_d;

  logic [7:0]  mem [DEPTH];
  logic [31:0] rd_bytes;
  logic [31:0] load_word;
  logic [31:0] wr_bytes;
  logic [3:0]  we;
  logic        wr_en;

  // Address increments wrap naturally in ADDR_W bits
  always_comb begin
    rd_bytes = '0;
    for (int i = 0; i < 4; i++) begin
      rd_bytes[8*(3-i) +: 8] =
        mem[addr_q + ADDR_W'(i)];
    end
  end

  ram_lane_align u_align (
    .opcode    (op_q),
    .rd_bytes  (rd_bytes),
    .data_in   (din_q),
    .load_word (load_word),
    .we        (we),
    .wr_bytes  (wr_bytes)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;
    mfc_d   = mfc_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.MFA) begin
          op_d    = bus.opcode;
          addr_d  = bus.addr;
          din_d   = bus.data_in;
          cnt_d   = '0;
          state_d = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == CNT_LAST) state_d = ACCESS;
        else cnt_d = cnt_q + 4'd1;
      end
      ACCESS: begin
        mfc_d   = 1'b1;
        state_d = DONE;
        if (is_load(op_q)) dout_d = load_word;
        else if (!is_store(op_q)) err_d = 1'b1;
      end
      DONE: begin
        if (!bus.MFA) begin
          mfc_d   = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      din_q   <= '0;
      dout_q  <= '0;
      mfc_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
      mfc_q   <= mfc_d;
      err_q   <= err_d;
    end
  end

  assign wr_en = (state_q == ACCESS) &&
                 is_store(op_q) && !reset;

  // Storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr_q + ADDR_W'(i)] <=
            wr_bytes[8*(3-i) +: 8];
        end
      end
    end
  end

  assign bus.data_out = dout_q;
  assign bus.MFC      = mfc_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_ram_handshake_responder.sv
// Directed self-checking bench for ram_handshake_responder
// (ADDR_W=8, WAIT_CYCLES=2).
module tb_ram_handshake_responder;
  import ram_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  ram_handshake_responder_if #(.ADDR_W(8)) bus ();

  ram_handshake_responder #(
    .ADDR_W      (8),
    .WAIT_CYCLES (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic txn(
    input  logic [5:0]  op,
    input  logic [7:0]  a,
    input  logic [31:0] d,
    output int          lat,
    output logic        e
  );
    @(negedge clk);
    bus.opcode  = op;
    bus.addr    = a;
    bus.data_in = d;
    bus.MFA     = 1'b1;
    lat = 0;
    e   = 1'b0;
    while (lat <= 50) begin
      @(posedge clk);
      #1;
      lat++;
      if (bus.MFC) break;
    end
    e = bus.err;
    @(negedge clk);
    bus.MFA = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.MFA     = 1'b0;
    bus.opcode  = '0;
    bus.addr    = '0;
    bus.data_in = '0;
    reset = 1'b0;
    #3 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.MFC !== 1'b0) begin
      errors++;
      $display("FAIL reset_mfc got %0b want 0", bus.MFC);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL reset_err got %0b want 0", bus.err);
    end
    checks++;
    if (bus.data_out !== 32'h0) begin
      errors++;
      $display("FAIL reset_dout got %h want 0",
               bus.data_out);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_store_load();
    int lat;
    logic e;
    txn(OP_SB, 8'h00, 32'h0000_0001, lat, e);
    txn(OP_SB, 8'h01, 32'h0000_0023, lat, e);
    txn(OP_SH, 8'h02, 32'h0000_4567, lat, e);
    txn(OP_LD, 8'h00, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'h0123_4567) begin
      errors++;
      $display("FAIL ld_00 got %h want 01234567",
               bus.data_out);
    end
    checks++;
    if (lat != 4) begin
      errors++;
      $display("FAIL latency got %0d want 4", lat);
    end
  endtask

  task automatic test_byte_loads();
    int lat;
    logic e;
    txn(OP_SW, 8'h04, 32'h89AB_CDEF, lat, e);
    txn(OP_LDUB, 8'h04, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'h0000_0089) begin
      errors++;
      $display("FAIL ldub_04 got %h want 00000089",
               bus.data_out);
    end
    txn(OP_LDSB, 8'h06, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'hFFFF_FFCD) begin
      errors++;
      $display("FAIL ldsb_06 got %h want ffffffcd",
               bus.data_out);
    end
    txn(OP_LDSB, 8'h00, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'h0000_0001) begin
      errors++;
      $display("FAIL ldsb_00 got %h want 00000001",
               bus.data_out);
    end
  endtask

  task automatic test_halfword_wrap();
    int lat;
    logic e;
    txn(OP_LDUH, 8'h06, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'h0000_CDEF) begin
      errors++;
      $display("FAIL lduh_06 got %h want 0000cdef",
               bus.data_out);
    end
    txn(OP_LDSH, 8'h06, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'hFFFF_CDEF) begin
      errors++;
      $display("FAIL ldsh_06 got %h want ffffcdef",
               bus.data_out);
    end
    txn(OP_LDUH, 8'h03, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'h0000_6789) begin
      errors++;
      $display("FAIL lduh_03 got %h want 00006789",
               bus.data_out);
    end
    txn(OP_SW, 8'hFE, 32'hAABB_CCDD, lat, e);
    txn(OP_LD, 8'hFE, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'hAABB_CCDD) begin
      errors++;
      $display("FAIL ld_fe got %h want aabbccdd",
               bus.data_out);
    end
  endtask

  task automatic test_illegal();
    int lat;
    logic e;
    txn(6'h3F, 8'h00, 32'h5555_5555, lat, e);
    checks++;
    if (lat != 4 || e !== 1'b1) begin
      errors++;
      $display("FAIL illegal_err lat %0d err %0b want 4 1",
               lat, e);
    end
    checks++;
    if (bus.data_out !== 32'hAABB_CCDD) begin
      errors++;
      $display("FAIL illegal_dout got %h want aabbccdd",
               bus.data_out);
    end
    checks++;
    if (bus.MFC !== 1'b0 || bus.err !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear mfc %0b err %0b want 0 0",
               bus.MFC, bus.err);
    end
    // bytes 0,1 were overwritten by the wrapping word store
    txn(OP_LD, 8'h00, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'hCCDD_4567) begin
      errors++;
      $display("FAIL illegal_mem got %h want ccdd4567",
               bus.data_out);
    end
  endtask

  task automatic test_input_change();
    int lat;
    logic e;
    int n;
    @(negedge clk);
    bus.opcode  = OP_SW;
    bus.addr    = 8'h10;
    bus.data_in = 32'h1122_3344;
    bus.MFA     = 1'b1;
    @(posedge clk);
    #1;
    bus.opcode  = OP_SB;
    bus.addr    = 8'h14;
    bus.data_in = 32'h0;
    n = 0;
    while (n < 50 && bus.MFC !== 1'b1) begin
      @(posedge clk);
      #1;
      n++;
    end
    @(negedge clk);
    bus.MFA = 1'b0;
    @(posedge clk);
    #1;
    txn(OP_LD, 8'h10, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'h1122_3344) begin
      errors++;
      $display("FAIL capture got %h want 11223344",
               bus.data_out);
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic e;
    txn(OP_SW, 8'h20, 32'h0BAD_F00D, lat, e);
    @(negedge clk);
    bus.opcode  = OP_SW;
    bus.addr    = 8'h20;
    bus.data_in = 32'hDEAD_BEEF;
    bus.MFA     = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if (bus.MFC !== 1'b0) begin
      errors++;
      $display("FAIL midrst_mfc got %0b want 0", bus.MFC);
    end
    checks++;
    if (bus.data_out !== 32'h0) begin
      errors++;
      $display("FAIL midrst_dout got %h want 0",
               bus.data_out);
    end
    checks++;
    if (dut.state_q !== IDLE) begin
      errors++;
      $display("FAIL midrst_state got %0d want 0",
               dut.state_q);
    end
    bus.MFA = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    txn(OP_LD, 8'h20, 32'h0, lat, e);
    checks++;
    if (bus.data_out !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL midrst_mem got %h want 0badf00d",
               bus.data_out);
    end
  endtask

  task automatic test_early_drop();
    int hi;
    int first;
    @(negedge clk);
    bus.opcode  = OP_LD;
    bus.addr    = 8'h04;
    bus.data_in = 32'h0;
    bus.MFA     = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.MFA = 1'b0;
    hi    = 0;
    first = 0;
    for (int i = 2; i <= 10; i++) begin
      @(posedge clk);
      #1;
      if (bus.MFC === 1'b1) begin
        if (hi == 0) first = i;
        hi++;
      end
    end
    checks++;
    if (hi != 1) begin
      errors++;
      $display("FAIL pulse_len got %0d want 1", hi);
    end
    checks++;
    if (first != 4) begin
      errors++;
      $display("FAIL pulse_edge got %0d want 4", first);
    end
    checks++;
    if (bus.data_out !== 32'h89AB_CDEF) begin
      errors++;
      $display("FAIL pulse_dout got %h want 89abcdef",
               bus.data_out);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_store_load();
    test_byte_loads();
    test_halfword_wrap();
    test_illegal();
    test_input_change();
    test_reset_mid();
    test_early_drop();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
